// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - state encoding and default constants for the song sequencer
package song_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEF_DRAW,
        S_DEF_FLUSH,
        S_WAIT_BEAT,
        S_SHIFT,
        S_BOX_SETUP,
        S_BOX_DRAW,
        S_BOX_FLUSH,
        S_SCORE_CHK,
        S_SCORE_ADD,
        S_DONE
    } state_t;

    localparam int DEF_W_DFLT       = 240;
    localparam int DEF_H_DFLT       = 180;
    localparam int BOX_W_DFLT       = 60;
    localparam int BOX_H_DFLT       = 60;
    localparam int NUM_BOXES_DFLT   = 12;
    localparam int SONG_BEATS_DFLT  = 112;
    localparam int BEAT_CYCLES_DFLT = 12500000;
    localparam int DEF_LAT_DFLT     = 2;
    localparam int PIX_LAT_DFLT     = 4;

endpackage

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - sequencer-to-datapath/VGA control bundle
interface song_sequencer_if;

    logic [15:0] gridCounter;
    logic [3:0]  boxCounter;
    logic [14:0] pixelCount;
    logic        loadDefault;
    logic        writeDefault;
    logic        shiftSong;
    logic        loadStartAddress;
    logic        loadX;
    logic        loadY;
    logic        writeToScreen;
    logic        changeScore;
    logic        addScore;
    logic        songDone;
    logic        plot;
    logic        busy;

    modport master (
        output gridCounter, boxCounter, pixelCount, loadDefault, writeDefault,
               shiftSong, loadStartAddress, loadX, loadY, writeToScreen,
               changeScore, addScore, songDone, plot, busy
    );

    modport slave (
        input  gridCounter, boxCounter, pixelCount, loadDefault, writeDefault,
               shiftSong, loadStartAddress, loadX, loadY, writeToScreen,
               changeScore, addScore, songDone, plot, busy
    );

endinterface

// File: rtl/song_sequencer_raster.sv
// rtl/song_sequencer_raster.sv - column-major x/y sweep counter (y fastest)
module raster_counter #(
    parameter int W  = 4,
    parameter int H  = 3,
    parameter int XW = (W > 1) ? $clog2(W) : 1,
    parameter int YW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (enable) begin
            if (y_q == Y_MAX) begin
                y_q <= '0;
                x_q <= (x_q == X_MAX) ? '0 : x_q + 1'b1;
            end else begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - per-song draw/shift/score FSM; SEQ_PAUSE_EN adds a beat-timer pause input
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int DEF_W       = DEF_W_DFLT,
    parameter int DEF_H       = DEF_H_DFLT,
    parameter int BOX_W       = BOX_W_DFLT,
    parameter int BOX_H       = BOX_H_DFLT,
    parameter int NUM_BOXES   = NUM_BOXES_DFLT,
    parameter int SONG_BEATS  = SONG_BEATS_DFLT,
    parameter int BEAT_CYCLES = BEAT_CYCLES_DFLT,
    parameter int DEF_LAT     = DEF_LAT_DFLT,
    parameter int PIX_LAT     = PIX_LAT_DFLT
) (
    input  logic              clock,
    input  logic              reset,
`ifdef SEQ_PAUSE_EN
    input  logic              pause,
`endif
    input  logic              start,
    song_sequencer_if.master  seq
);

    localparam int TT   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int BT   = $clog2(SONG_BEATS + 1);
    localparam int WMAX = (DEF_LAT > PIX_LAT) ? ((DEF_LAT > 2) ? DEF_LAT : 2)
                                              : ((PIX_LAT > 2) ? PIX_LAT : 2);
    localparam int WT   = $clog2(WMAX);
    localparam int DXW  = (DEF_W > 1) ? $clog2(DEF_W) : 1;
    localparam int DYW  = (DEF_H > 1) ? $clog2(DEF_H) : 1;
    localparam int BXW  = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int BYW  = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    state_t            state_q, state_d;
    logic [TT-1:0]     timer_q, timer_d;
    logic [BT-1:0]     beat_q, beat_d;
    logic [3:0]        box_q, box_d;
    logic [WT-1:0]     wait_q, wait_d;
    logic [DEF_LAT-1:0] def_pipe_q;
    logic [PIX_LAT-1:0] pix_pipe_q;

    logic ld_def, wr_def, shift, lsa, lxy, wts, chg, add, done, run;
    logic [DXW-1:0] def_x;
    logic [DYW-1:0] def_y;
    logic [BXW-1:0] box_x;
    logic [BYW-1:0] box_y;
    logic           def_last, box_last;

`ifdef SEQ_PAUSE_EN
    assign run = !pause;
`else
    assign run = 1'b1;
`endif

    raster_counter #(.W(DEF_W), .H(DEF_H)) u_def_raster (
        .clk(clock), .clear(reset || state_q == S_IDLE), .enable(state_q == S_DEF_DRAW),
        .x(def_x), .y(def_y), .last(def_last)
    );

    raster_counter #(.W(BOX_W), .H(BOX_H)) u_box_raster (
        .clk(clock), .clear(reset || state_q == S_BOX_SETUP), .enable(state_q == S_BOX_DRAW),
        .x(box_x), .y(box_y), .last(box_last)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        beat_d  = beat_q;
        box_d   = box_q;
        wait_d  = wait_q;
        ld_def  = 1'b0;
        wr_def  = 1'b0;
        shift   = 1'b0;
        lsa     = 1'b0;
        lxy     = 1'b0;
        wts     = 1'b0;
        chg     = 1'b0;
        add     = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_DEF_DRAW;
            S_DEF_DRAW: begin
                ld_def = 1'b1;
                wr_def = 1'b1;
                if (def_last) begin
                    state_d = S_DEF_FLUSH;
                    wait_d  = '0;
                end
            end
            S_DEF_FLUSH: begin
                wr_def = 1'b1;
                if (wait_q == WT'(DEF_LAT - 1)) begin
                    state_d = S_WAIT_BEAT;
                    timer_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            // The timer only advances here, so redraw time adds to the beat period.
            S_WAIT_BEAT: begin
                if (run) begin
                    if (timer_q == TT'(BEAT_CYCLES - 1)) state_d = S_SHIFT;
                    else                                 timer_d = timer_q + 1'b1;
                end
            end
            S_SHIFT: begin
                shift   = 1'b1;
                state_d = S_BOX_SETUP;
                box_d   = 4'd1;
                wait_d  = '0;
            end
            S_BOX_SETUP: begin
                lsa = 1'b1;
                if (wait_q == WT'(1)) state_d = S_BOX_DRAW;
                else                  wait_d  = wait_q + 1'b1;
            end
            S_BOX_DRAW: begin
                lxy = 1'b1;
                wts = 1'b1;
                if (box_last) begin
                    state_d = S_BOX_FLUSH;
                    wait_d  = '0;
                end
            end
            S_BOX_FLUSH: begin
                wts = 1'b1;
                if (wait_q == WT'(PIX_LAT - 1)) begin
                    wait_d = '0;
                    if (box_q < 4'(NUM_BOXES)) begin
                        box_d   = box_q + 1'b1;
                        state_d = S_BOX_SETUP;
                    end else begin
                        box_d   = '0;
                        state_d = S_SCORE_CHK;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_SCORE_CHK: begin
                chg     = 1'b1;
                state_d = S_SCORE_ADD;
            end
            S_SCORE_ADD: begin
                add    = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_d == BT'(SONG_BEATS)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_BEAT;
                    timer_d = '0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                beat_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            beat_q     <= '0;
            box_q      <= '0;
            wait_q     <= '0;
            def_pipe_q <= '0;
            pix_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            beat_q     <= beat_d;
            box_q      <= box_d;
            wait_q     <= wait_d;
            def_pipe_q <= (def_pipe_q << 1) | DEF_LAT'(ld_def);
            pix_pipe_q <= (pix_pipe_q << 1) | PIX_LAT'(lxy);
        end
    end

    // Outputs are masked while reset is high so an aborted draw emits no stray strobe.
    assign seq.gridCounter      = reset ? '0 : {8'(def_x), 8'(def_y)};
    assign seq.pixelCount       = reset ? '0 : {8'(box_x), 7'(box_y)};
    assign seq.boxCounter       = reset ? '0 : box_q;
    assign seq.loadDefault      = ld_def && !reset;
    assign seq.writeDefault     = wr_def && !reset;
    assign seq.shiftSong        = shift  && !reset;
    assign seq.loadStartAddress = lsa    && !reset;
    assign seq.loadX            = lxy    && !reset;
    assign seq.loadY            = lxy    && !reset;
    assign seq.writeToScreen    = wts    && !reset;
    assign seq.changeScore      = chg    && !reset;
    assign seq.addScore         = add    && !reset;
    assign seq.songDone         = done   && !reset;
    assign seq.plot             = (def_pipe_q[DEF_LAT-1] || pix_pipe_q[PIX_LAT-1]) && !reset;
    assign seq.busy             = (state_q != S_IDLE) && !reset;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer with a reduced geometry
module tb_song_sequencer;

    localparam int DEF_W = 4, DEF_H = 3, BOX_W = 2, BOX_H = 2, NUM_BOXES = 12;
    localparam int SONG_BEATS = 3, BEAT_CYCLES = 5, DEF_LAT = 2, PIX_LAT = 4;
    localparam int BOX_PLOTS = NUM_BOXES * BOX_W * BOX_H;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
`ifdef SEQ_PAUSE_EN
    logic pause = 1'b0;
`endif

    song_sequencer_if sif ();

    song_sequencer #(
        .DEF_W(DEF_W), .DEF_H(DEF_H), .BOX_W(BOX_W), .BOX_H(BOX_H),
        .NUM_BOXES(NUM_BOXES), .SONG_BEATS(SONG_BEATS), .BEAT_CYCLES(BEAT_CYCLES),
        .DEF_LAT(DEF_LAT), .PIX_LAT(PIX_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
`ifdef SEQ_PAUSE_EN
        .pause(pause),
`endif
        .start(start),
        .seq(sif)
    );

    always #5 clock = ~clock;

    logic [46:0] all_out;
    assign all_out = {sif.gridCounter, sif.boxCounter, sif.pixelCount, sif.loadDefault,
                      sif.writeDefault, sif.shiftSong, sif.loadStartAddress, sif.loadX,
                      sif.loadY, sif.writeToScreen, sif.changeScore, sif.addScore,
                      sif.songDone, sif.plot, sif.busy};

    int n_tests = 0, n_fail = 0;
    int cyc = 0, anchor = 0, pause_extra = 0;
    int n_shift = 0, n_add = 0, n_done = 0, n_dplot = 0, n_bplot = 0, n_wd = 0;
    int b_shift, b_add, b_done, b_dplot, b_bplot, b_wd;
    logic anchor_wd = 1'b0, prev_chg = 1'b0, prev_add = 1'b0, prev_done = 1'b0;
    logic [DEF_LAT-1:0] dpipe = '0;
    logic [PIX_LAT-1:0] xpipe = '0;
    logic exp_d, exp_x, found, seen_wd;
    logic [15:0] exp_grid[$];
    logic [18:0] exp_box[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_song(input int songs);
        for (int s = 0; s < songs; s++) begin
            for (int x = 0; x < DEF_W; x++)
                for (int y = 0; y < DEF_H; y++)
                    exp_grid.push_back({8'(x), 8'(y)});
            for (int b = 0; b < SONG_BEATS; b++)
                for (int n = 1; n <= NUM_BOXES; n++)
                    for (int x = 0; x < BOX_W; x++)
                        for (int y = 0; y < BOX_H; y++)
                            exp_box.push_back({4'(n), 8'(x), 7'(y)});
        end
    endtask

    task automatic snap();
        b_shift = n_shift; b_add = n_add; b_done = n_done;
        b_dplot = n_dplot; b_bplot = n_bplot; b_wd = n_wd;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 3000 && n_done < target; i++) @(posedge clock);
        @(negedge clock);
        check(tag, n_done, target);
    endtask

    task automatic song_totals(input int songs, input string tag);
        check({tag, "_shifts"}, n_shift - b_shift, songs * SONG_BEATS);
        check({tag, "_adds"}, n_add - b_add, songs * SONG_BEATS);
        check({tag, "_dones"}, n_done - b_done, songs);
        check({tag, "_def_plots"}, n_dplot - b_dplot, songs * DEF_W * DEF_H);
        check({tag, "_box_plots"}, n_bplot - b_bplot, songs * SONG_BEATS * BOX_PLOTS);
        check({tag, "_wd_cycles"}, n_wd - b_wd, songs * (DEF_W * DEF_H + DEF_LAT));
        check({tag, "_grid_left"}, exp_grid.size(), 0);
        check({tag, "_box_left"}, exp_box.size(), 0);
        check({tag, "_busy_idle"}, sif.busy, 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                cyc++;
                if (reset) begin
                    check("reset_outputs", all_out, 0);
                    dpipe = '0; xpipe = '0;
                    prev_chg = 1'b0; prev_add = 1'b0; prev_done = 1'b0;
                end else begin
                    exp_d = dpipe[DEF_LAT-1];
                    exp_x = xpipe[PIX_LAT-1];
                    check("plot_timing", sif.plot, exp_d | exp_x);
                    if (exp_d) n_dplot++;
                    if (exp_x) n_bplot++;
                    dpipe = {dpipe[DEF_LAT-2:0], sif.loadDefault};
                    xpipe = {xpipe[PIX_LAT-2:0], sif.loadX};
                    if (sif.loadDefault) begin
                        if (exp_grid.size() == 0) check("grid_extra", 1, 0);
                        else check("grid", sif.gridCounter, exp_grid.pop_front());
                        check("wd_with_ld", sif.writeDefault, 1);
                    end
                    if (sif.loadX) begin
                        if (exp_box.size() == 0) check("box_extra", 1, 0);
                        else check("box_pix", {sif.boxCounter, sif.pixelCount}, exp_box.pop_front());
                        check("loady_wts", {sif.loadY, sif.writeToScreen}, 2'b11);
                    end
                    check("mux_excl", sif.writeDefault & sif.writeToScreen, 0);
                    if (sif.writeDefault) begin
                        n_wd++; anchor = cyc; anchor_wd = 1'b1;
                    end
                    if (sif.shiftSong) begin
                        n_shift++;
                        check("shift_gap", cyc - anchor, 6 + (anchor_wd ? pause_extra : 0));
                    end
                    if (sif.addScore) begin
                        n_add++;
                        check("chg_then_add", prev_chg, 1);
                        anchor = cyc; anchor_wd = 1'b0;
                    end
                    if (prev_done) check("busy_after_done", sif.busy, 0);
                    if (sif.songDone) begin
                        n_done++;
                        check("add_then_done", prev_add, 1);
                    end
                    prev_chg = sif.changeScore; prev_add = sif.addScore; prev_done = sif.songDone;
                end
            end
        join_none

        // Reset and idle state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", all_out, 0);

        // One full song from a single start pulse
        snap();
        push_song(1);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done(b_done + 1, "song1_done");
        @(negedge clock);
        song_totals(1, "song1");

        // Reset in the middle of box 5
        push_song(1);
        found = 1'b0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (sif.loadX && sif.boxCounter == 4'd5 && sif.pixelCount == 15'd0) begin
                found = 1'b1;
                break;
            end
        end
        check("box5_reached", found, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("post_reset_outputs", all_out, 0);
        exp_grid.delete();
        exp_box.delete();
        snap();
        repeat (8) @(negedge clock);
        check("no_pipe_plots", (n_bplot - b_bplot) + (n_dplot - b_dplot), 0);
        check("still_idle", sif.busy, 0);

        // start held through DONE restarts only via IDLE
        snap();
        push_song(2);
        @(posedge clock); #1 start = 1'b1;
        wait_done(b_done + 1, "held_first_done");
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (sif.loadDefault) begin
                found = 1'b1;
                break;
            end
        end
        check("held_restart", found, 1);
        #1 start = 1'b0;
        wait_done(b_done + 2, "held_second_done");
        @(negedge clock);
        song_totals(2, "held");

`ifdef SEQ_PAUSE_EN
        // Pause for 20 cycles in the first WAIT_BEAT
        snap();
        push_song(1);
        pause_extra = 20;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        found = 1'b0;
        seen_wd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sif.writeDefault) seen_wd = 1'b1;
            else if (seen_wd) begin
                found = 1'b1;
                break;
            end
        end
        check("pause_wait_entered", found, 1);
        pause = 1'b1;
        repeat (20) @(posedge clock);
        #1 pause = 1'b0;
        wait_done(b_done + 1, "pause_done");
        @(negedge clock);
        song_totals(1, "pause");
        pause_extra = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
